// File: rtl/sck_control_pkg.sv
// Shared types and defaults for the SPI serial-clock controller.
package sck_control_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2
    } state_e;

    // Encoding is {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } mode_e;

endpackage

// File: rtl/sck_edge_detect.sv
// Baud-rate edge detector with optional 2-flop input synchronizer.
// Define SCK_CONTROL_SYNC_EN to insert the synchronizer (adds 2 clk of latency).
module sck_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_baud,
    output logic o_rise,
    output logic o_fall
);

    logic w_baud;
    logic r_hist;

`ifdef SCK_CONTROL_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_baud;
            r_sync2 <= r_sync1;
        end
    end

    assign w_baud = r_sync2;
`else
    assign w_baud = i_baud;
`endif

    // History always tracks the baud level, so leaving IDLE while baud is high
    // cannot produce a spurious rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= 1'b0;
        else        r_hist <= w_baud;
    end

    assign o_rise = w_baud & ~r_hist;
    assign o_fall = ~w_baud & r_hist;

endmodule

// File: rtl/sck_control.sv
// SPI SCK generator: turns the baud square wave into SCK plus shift/sample/frame pulses.
// Optional macro SCK_CONTROL_SYNC_EN adds an input synchronizer on M_BaudRate.
module sck_control
    import sck_control_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic M_BaudRate,
    input  logic CPOL,
    input  logic CPHA,
    input  logic idle,
    output logic SCK_out,
    output logic Shift_clk,
    output logic Sample_clk,
    output logic frame_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_e           r_state;
    mode_e            r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sck;
    logic             r_sck_vld;
    logic             r_shift;
    logic             r_sample;
    logic             r_done;
    logic             w_rise;
    logic             w_fall;
    logic             w_cpol_l;
    logic             w_cpha_l;

    sck_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_baud (M_BaudRate),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_cpol_l = r_mode[1];
    assign w_cpha_l = r_mode[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= MODE0;
            r_cnt     <= '0;
            r_sck     <= 1'b0;
            r_sck_vld <= 1'b0;
            r_shift   <= 1'b0;
            r_sample  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_sck_vld <= 1'b1;
            r_shift   <= 1'b0;
            r_sample  <= 1'b0;
            r_done    <= 1'b0;
            if (idle) begin
                r_state <= IDLE;
                r_sck   <= CPOL;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_mode  <= mode_e'({CPOL, CPHA});
                        r_sck   <= CPOL;
                        r_cnt   <= '0;
                        r_state <= LEAD;
                    end
                    LEAD: begin
                        if (w_rise) begin
                            r_sck    <= ~w_cpol_l;
                            r_shift  <= w_cpha_l;
                            r_sample <= ~w_cpha_l;
                            r_state  <= TRAIL;
                        end
                    end
                    TRAIL: begin
                        if (w_fall) begin
                            r_sck    <= w_cpol_l;
                            r_shift  <= ~w_cpha_l;
                            r_sample <= w_cpha_l;
                            r_state  <= LEAD;
                            if (r_cnt == LAST_BIT) begin
                                r_done <= 1'b1;
                                r_cnt  <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Until the first clock after reset, SCK follows the live CPOL input.
    assign SCK_out    = r_sck_vld ? r_sck : CPOL;
    assign Shift_clk  = r_shift;
    assign Sample_clk = r_sample;
    assign frame_done = r_done;

endmodule

// File: tb/tb_sck_control.sv
// Self-checking bench for sck_control against a behavioural SPI clocking model.
module tb_sck_control;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic M_BaudRate;
    logic CPOL;
    logic CPHA;
    logic idle;
    logic SCK_out;
    logic Shift_clk;
    logic Sample_clk;
    logic frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: frame active, SCK in its active half, bits done in this frame.
    logic m_act, m_high, m_prev, m_s1, m_s2, m_cpol, m_cpha, m_sck;
    int   m_bits;

    sck_control #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .M_BaudRate (M_BaudRate),
        .CPOL       (CPOL),
        .CPHA       (CPHA),
        .idle       (idle),
        .SCK_out    (SCK_out),
        .Shift_clk  (Shift_clk),
        .Sample_clk (Sample_clk),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_act = 0; m_high = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
        m_bits = 0; m_cpol = 0; m_cpha = 0; m_sck = 0;
    endtask

    // Expected {SCK, Shift, Sample, done} after the clock edge that sees (id, b).
    task automatic model_step(input logic id, input logic b, output logic [3:0] e);
        logic w, rise, fall, sh, sa, dn;
`ifdef SCK_CONTROL_SYNC_EN
        w = m_s2; m_s2 = m_s1; m_s1 = b;
`else
        w = b;
`endif
        rise = w & ~m_prev;
        fall = ~w & m_prev;
        m_prev = w;
        sh = 0; sa = 0; dn = 0;
        if (id) begin
            m_act = 0;
            m_sck = CPOL;
        end else if (!m_act) begin
            m_act = 1; m_high = 0; m_bits = 0;
            m_cpol = CPOL; m_cpha = CPHA; m_sck = CPOL;
        end else if (!m_high && rise) begin
            m_high = 1; m_sck = ~m_cpol;
            if (m_cpha) sh = 1; else sa = 1;
        end else if (m_high && fall) begin
            m_high = 0; m_sck = m_cpol;
            if (m_cpha) sa = 1; else sh = 1;
            m_bits++;
            if (m_bits == DW) begin
                dn = 1; m_bits = 0;
            end
        end
        e = {m_sck, sh, sa, dn};
    endtask

    // Called at a negedge: drive one cycle of inputs, return observed/expected.
    task automatic tick(input logic id, input logic b, output logic [3:0] obs, output logic [3:0] e);
        idle = id;
        M_BaudRate = b;
        model_step(id, b, e);
        @(negedge clk);
        obs = {SCK_out, Shift_clk, Sample_clk, frame_done};
    endtask

    task automatic test_reset();
        logic [3:0] obs, e;
        rst_n = 0; idle = 1; M_BaudRate = 0; CPOL = 1; CPHA = 0;
        model_reset();
        #1;
        n_checks++;
        if ({SCK_out, Shift_clk, Sample_clk, frame_done} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_cpol1: got %b expected 1000", {SCK_out, Shift_clk, Sample_clk, frame_done});
        end
        CPOL = 0;
        #1;
        n_checks++;
        if ({SCK_out, Shift_clk, Sample_clk, frame_done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_cpol0: got %b expected 0000", {SCK_out, Shift_clk, Sample_clk, frame_done});
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, obs, e);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    // One frame of DW random-width baud periods in the given mode.
    task automatic test_mode(input logic pol, input logic pha);
        logic [3:0] obs, e;
        logic prev_sck;
        int n_sa, n_sh, n_dn, n_tog, n_bad_place, h, l;
        n_sa = 0; n_sh = 0; n_dn = 0; n_tog = 0; n_bad_place = 0;
        CPOL = pol; CPHA = pha;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, obs, e);
        prev_sck = obs[3];
        n_checks++;
        if (obs[3] !== pol) begin
            n_errors++;
            $display("FAIL mode%0d_idle_level: got %b expected %b", {pol, pha}, obs[3], pol);
        end
        tick(1'b0, 1'b0, obs, e);
        for (int p = 0; p < DW + 1; p++) begin
            h = (p < DW) ? int'($urandom_range(1, 3)) : 0;
            l = (p < DW) ? int'($urandom_range(1, 3)) : 4;
            for (int c = 0; c < h + l; c++) begin
                tick(1'b0, (c < h), obs, e);
                n_checks++;
                if (obs !== e) begin
                    n_errors++;
                    $display("FAIL mode%0d_cycle p%0d c%0d: got %b expected %b", {pol, pha}, p, c, obs, e);
                end
                if (obs[3] !== prev_sck) n_tog++;
                prev_sck = obs[3];
                n_sh += obs[2]; n_sa += obs[1]; n_dn += obs[0];
                // Leading-edge pulses coincide with SCK leaving its idle level.
                if (obs[1] && (obs[3] !== (pha ? pol : ~pol))) n_bad_place++;
                if (obs[2] && (obs[3] !== (pha ? ~pol : pol))) n_bad_place++;
            end
        end
        n_checks++;
        if (n_sa != DW || n_sh != DW || n_dn != 1 || n_tog != 2 * DW) begin
            n_errors++;
            $display("FAIL mode%0d_counts: got sample=%0d shift=%0d done=%0d toggles=%0d expected %0d/%0d/1/%0d",
                     {pol, pha}, n_sa, n_sh, n_dn, n_tog, DW, DW, 2 * DW);
        end
        n_checks++;
        if (n_bad_place != 0) begin
            n_errors++;
            $display("FAIL mode%0d_pulse_edge: got %0d misplaced pulses expected 0", {pol, pha}, n_bad_place);
        end
        tick(1'b1, 1'b0, obs, e);
    endtask

    task automatic test_abort();
        logic [3:0] obs, e;
        int n_dn, n_trail;
        CPOL = 0; CPHA = 0; n_dn = 0;
        tick(1'b1, 1'b0, obs, e);
        tick(1'b0, 1'b0, obs, e);
        for (int p = 0; p < 3; p++) begin
            tick(1'b0, 1'b1, obs, e); n_dn += obs[0];
            tick(1'b0, 1'b0, obs, e); n_dn += obs[0];
        end
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 1'b1, obs, e); n_dn += obs[0];
        end
        CPOL = 1;
        tick(1'b1, 1'b1, obs, e);
        n_checks++;
        if (obs !== 4'b1000) begin
            n_errors++;
            $display("FAIL abort_next_clk: got %b expected 1000", obs);
        end
        n_checks++;
        if (n_dn != 0) begin
            n_errors++;
            $display("FAIL abort_no_done: got %0d frame_done expected 0", n_dn);
        end
        CPOL = 0;
        tick(1'b1, 1'b0, obs, e);
        tick(1'b0, 1'b0, obs, e);
        n_trail = 0;
        for (int p = 0; p < DW; p++) begin
            for (int c = 0; c < 6; c++) begin
                tick(1'b0, (c < 3), obs, e);
                n_checks++;
                if (obs !== e) begin
                    n_errors++;
                    $display("FAIL abort_restart p%0d c%0d: got %b expected %b", p, c, obs, e);
                end
                n_trail += obs[2];
                if (obs[0] && n_trail != DW) begin
                    n_checks++; n_errors++;
                    $display("FAIL abort_restart_count: got done after %0d bits expected %0d", n_trail, DW);
                end
            end
        end
    endtask

    task automatic test_idle_release_high();
        logic [3:0] obs, e;
        int n_pulse;
        CPOL = 0; CPHA = 0; n_pulse = 0;
        tick(1'b1, 1'b1, obs, e);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b1, obs, e);
            n_pulse += obs[2] + obs[1];
        end
        n_checks++;
        if (n_pulse != 0 || obs[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL release_high: got %0d pulses sck=%b expected 0 pulses sck=0", n_pulse, obs[3]);
        end
        tick(1'b0, 1'b0, obs, e);
        CPOL = 1;
        tick(1'b0, 1'b1, obs, e);
        n_checks++;
        if (obs !== 4'b1010 || obs !== e) begin
            n_errors++;
            $display("FAIL release_first_rise: got %b expected 1010", obs);
        end
        tick(1'b0, 1'b0, obs, e);
        n_checks++;
        if (obs !== 4'b0100) begin
            n_errors++;
            $display("FAIL cpol_mid_frame: got %b expected 0100", obs);
        end
        // Idle and a rising baud edge in the same cycle: idle wins.
        tick(1'b1, 1'b1, obs, e);
        n_checks++;
        if (obs !== 4'b1000) begin
            n_errors++;
            $display("FAIL idle_vs_edge: got %b expected 1000", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, e;
        int n_dn;
        CPOL = 1'($urandom); CPHA = 1'($urandom); n_dn = 0;
        tick(1'b1, 1'b0, obs, e);
        tick(1'b0, 1'b0, obs, e);
        for (int p = 0; p < 2 * DW; p++) begin
            for (int c = 0; c < 2; c++) begin
                tick(1'b0, (c == 0), obs, e);
                n_checks++;
                if (obs !== e) begin
                    n_errors++;
                    $display("FAIL b2b p%0d c%0d: got %b expected %b", p, c, obs, e);
                end
                n_dn += obs[0];
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b0, obs, e);
            n_dn += obs[0];
        end
        n_checks++;
        if (n_dn != 2) begin
            n_errors++;
            $display("FAIL b2b_frames: got %0d frame_done expected 2", n_dn);
        end
    endtask

    task automatic test_random();
        logic [3:0] obs, e;
        logic b, id;
        int run;
        b = 0; id = 1; run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                b = ~b;
                run = $urandom_range(1, 4);
            end
            run--;
            if ($urandom_range(0, 60) == 0) id = ~id;
            if ($urandom_range(0, 40) == 0) CPOL = ~CPOL;
            if ($urandom_range(0, 40) == 0) CPHA = ~CPHA;
            tick(id, b, obs, e);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %b expected %b", i, obs, e);
            end
            if (obs[2] && obs[1]) begin
                n_checks++; n_errors++;
                $display("FAIL pulse_exclusive cyc %0d: got shift=1 sample=1 expected not both", i);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] obs, e;
        CPOL = 1; CPHA = 1;
        tick(1'b1, 1'b0, obs, e);
        tick(1'b0, 1'b0, obs, e);
        tick(1'b0, 1'b1, obs, e);
        tick(1'b0, 1'b0, obs, e);
        tick(1'b0, 1'b1, obs, e);
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({SCK_out, Shift_clk, Sample_clk, frame_done} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_mid_frame: got %b expected 1000", {SCK_out, Shift_clk, Sample_clk, frame_done});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, (i >= 2), obs, e);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL after_reset cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        tick(1'b1, 1'b0, obs, e);
    endtask

    initial begin
        test_reset();
        test_mode(1'b0, 1'b0);
        test_mode(1'b0, 1'b1);
        test_mode(1'b1, 1'b0);
        test_mode(1'b1, 1'b1);
        test_abort();
        test_idle_release_high();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
